// File: rtl/wifi_phy_pkg.sv
// Shared WiFi PHY receive-side definitions: descrambler FSM encoding,
// scrambler polynomial taps and frame-field lengths.
package wifi_phy_pkg;

  localparam int unsigned SCR_LEN         = 7;
  localparam int unsigned TAP_A           = 7;
  localparam int unsigned TAP_B           = 4;
  localparam int unsigned SEED_LEN_DEF    = 7;
  localparam int unsigned SERVICE_LEN_DEF = 16;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SERVICE,
    ST_DATA,
    ST_DONE
  } desc_state_e;

  // Feedback of the x^7+x^4+1 scrambler, register indexed s[7:1]
  function automatic logic scr_fb(input logic [SCR_LEN:1] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/wifi_bit_packer.sv
// Serial-to-byte packer: first pushed bit lands in byte_o[0]; byte_o and
// valid_o update on the edge that accepts the eighth bit.
module wifi_bit_packer
  import wifi_phy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              bit_i,
  input  logic              clear_i,
  output logic              last_bit_c,
  output logic [BYTE_W-1:0] byte_o,
  output logic              valid_o
);

  localparam int unsigned POS_W = $clog2(BYTE_W);

  logic [POS_W-1:0]  pos_q;
  logic [BYTE_W-1:0] shreg_q;
  logic [BYTE_W-1:0] byte_q;
  logic              valid_q;

  always_comb begin
    last_bit_c = push_i && (pos_q == POS_W'(BYTE_W - 1));
  end

  // A push that completes a byte still emits it even when clear_i is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (push_i) begin
        shreg_q <= {bit_i, shreg_q[BYTE_W-1:1]};
        if (last_bit_c) begin
          byte_q  <= {bit_i, shreg_q[BYTE_W-1:1]};
          valid_q <= 1'b1;
          pos_q   <= '0;
        end else begin
          pos_q <= pos_q + POS_W'(1);
        end
      end
      if (clear_i) begin
        pos_q <= '0;
      end
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wifi_descrambler.sv
// 802.11 descrambler: recovers the seed from the first SERVICE bits, checks
// and strips SERVICE, then emits descrambled PSDU bytes LSB-first.
module wifi_descrambler
  import wifi_phy_pkg::*;
#(
  parameter int unsigned SERVICE_LEN = SERVICE_LEN_DEF,
  parameter int unsigned SEED_LEN    = SEED_LEN_DEF,
  parameter int unsigned CNT_W       = 12
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              valid_in,
  input  logic              data_in,
  input  logic              finished_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic [SCR_LEN-1:0] seed_out,
  output logic [CNT_W-1:0]  byte_count,
  output logic              service_err,
  output logic              done
);

  localparam int unsigned BCNT_W = $clog2(SERVICE_LEN + 1);

  desc_state_e        state_q;
  logic [SCR_LEN:1]   s_q;
  logic [BCNT_W-1:0]  bcnt_q;
  logic [SCR_LEN-1:0] seed_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               done_q;

  logic fb_c;
  logic desc_c;
  logic push_c;
  logic clear_c;
  logic last_bit_c;

  always_comb begin
    fb_c    = scr_fb(s_q);
    desc_c  = data_in ^ fb_c;
    push_c  = enable && valid_in && (state_q == ST_DATA);
    clear_c = !enable || (state_q != ST_DATA) || finished_in;
  end

  // Frame FSM, scrambler register and per-frame status
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      bcnt_q  <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (last_bit_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (!enable) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (valid_in) begin
              cnt_q   <= '0;
              err_q   <= 1'b0;
              seed_q  <= '0;
              s_q     <= {s_q[SCR_LEN-1:1], data_in};
              bcnt_q  <= BCNT_W'(1);
              state_q <= ST_SEED;
            end
          end
          ST_SEED: begin
            if (valid_in) begin
              s_q    <= {s_q[SCR_LEN-1:1], data_in};
              bcnt_q <= bcnt_q + BCNT_W'(1);
              if (bcnt_q == BCNT_W'(SEED_LEN - 1)) begin
                seed_q  <= {s_q[SCR_LEN-1:1], data_in};
                state_q <= ST_SERVICE;
              end
            end
            if (finished_in) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_SERVICE: begin
            if (valid_in) begin
              s_q    <= {s_q[SCR_LEN-1:1], fb_c};
              bcnt_q <= bcnt_q + BCNT_W'(1);
              if (desc_c) begin
                err_q <= 1'b1;
              end
              if (bcnt_q == BCNT_W'(SERVICE_LEN - 1)) begin
                state_q <= ST_DATA;
              end
            end
            if (finished_in) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DATA: begin
            if (valid_in) begin
              s_q <= {s_q[SCR_LEN-1:1], fb_c};
            end
            if (finished_in) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  wifi_bit_packer u_packer (
    .clk        (clk),
    .rst_n      (RESET),
    .push_i     (push_c),
    .bit_i      (desc_c),
    .clear_i    (clear_c),
    .last_bit_c (last_bit_c),
    .byte_o     (data_out),
    .valid_o    (valid_out)
  );

  assign seed_out    = seed_q;
  assign byte_count  = cnt_q;
  assign service_err = err_q;
  assign done        = done_q;

endmodule

// File: tb/tb_wifi_descrambler.sv
// Directed bench for wifi_descrambler: table of frame scenarios driven from a
// bench-side 802.11 scrambler, plus reset and enable abort sequences.
module tb_wifi_descrambler;

  logic       clk = 1'b0;
  logic       RESET;
  logic       enable;
  logic       valid_in;
  logic       data_in;
  logic       finished_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [6:0] seed_out;
  logic [11:0] byte_count;
  logic       service_err;
  logic       done;

  always #5 clk = ~clk;

  wifi_descrambler dut (
    .clk         (clk),
    .RESET       (RESET),
    .enable      (enable),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .finished_in (finished_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .seed_out    (seed_out),
    .byte_count  (byte_count),
    .service_err (service_err),
    .done        (done)
  );

  typedef struct {
    logic [6:0] seed;
    int         flip;
    bit         stall;
    int         fin_idx;
    int         exp_n;
    bit         exp_err;
    int         exp_coinc;
    string      name;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] got[$];
  int         done_cnt;
  int         coinc_cnt;
  logic [7:0] psdu[4] = '{8'h04, 8'h02, 8'h00, 8'h2E};
  bit         fbits[$];
  vec_t       vecs[7];

  // Output monitor on the falling edge
  always @(negedge clk) begin
    if (valid_out) begin
      got.push_back(data_out);
      if (done) coinc_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Transmit model: seed bits, scrambled zero SERVICE, PSDU LSB-first, 6 tail bits
  task automatic build(input logic [6:0] seed, input int flip);
    logic [6:0] st;
    logic [7:0] b;
    logic       fb;
    logic       p;
    fbits.delete();
    st = seed;
    for (int i = 0; i < 7; i++) fbits.push_back(seed[6-i]);
    for (int i = 7; i < 16 + 32 + 6; i++) begin
      if (i >= 16 && i < 48) begin
        b = psdu[(i-16)/8];
        p = b[(i-16)%8];
      end else begin
        p = 1'b0;
      end
      fb = st[6] ^ st[3];
      st = {st[5:0], fb};
      fbits.push_back(p ^ fb);
    end
    if (flip >= 0) fbits[flip] = ~fbits[flip];
  endtask

  task automatic drive_bits(input int first, input int last, input bit stall, input int fin_idx);
    for (int i = first; i <= last; i++) begin
      if (stall) begin
        int g;
        g = $urandom_range(1, 5);
        valid_in    = 1'b0;
        finished_in = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      valid_in    = 1'b1;
      data_in     = fbits[i];
      finished_in = (i == fin_idx);
      @(posedge clk); #1;
    end
    valid_in    = 1'b0;
    finished_in = 1'b0;
    data_in     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int last;
    int k;
    build(v.seed, v.flip);
    got.delete();
    done_cnt  = 0;
    coinc_cnt = 0;
    last = (v.fin_idx >= 0) ? v.fin_idx : fbits.size() - 1;
    drive_bits(0, last, v.stall, v.fin_idx);
    if (v.fin_idx < 0) begin
      finished_in = 1'b1;
      @(posedge clk); #1;
      finished_in = 1'b0;
    end
    for (k = 0; k < 20; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk({v.name, "_done_lat"}, k, 0);
    @(posedge clk); #1;
    chk({v.name, "_done_cnt"}, done_cnt, 1);
    chk({v.name, "_coinc"}, coinc_cnt, v.exp_coinc);
    chk({v.name, "_seed"}, int'(seed_out), int'(v.seed));
    chk({v.name, "_nbytes"}, got.size(), v.exp_n);
    chk({v.name, "_byte_count"}, int'(byte_count), v.exp_n);
    chk({v.name, "_service_err"}, int'(service_err), int'(v.exp_err));
    for (int i = 0; i < v.exp_n && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", v.name, i), int'(got[i]), int'(psdu[i]));
  endtask

  initial begin
    vecs[0] = '{7'h5D, -1, 1'b0, -1, 4, 1'b0, 0, "golden"};
    vecs[1] = '{7'h5D, 10, 1'b0, -1, 4, 1'b1, 0, "svc_corrupt"};
    vecs[2] = '{7'h5D, -1, 1'b1, -1, 4, 1'b0, 0, "stalled"};
    vecs[3] = '{7'h7F, -1, 1'b1, -1, 4, 1'b0, 0, "b2b_seed7f"};
    vecs[4] = '{7'h5D, -1, 1'b0, 39, 3, 1'b0, 1, "coinc_last"};
    vecs[5] = '{7'h5D, -1, 1'b0, 44, 3, 1'b0, 0, "partial_byte"};
    vecs[6] = '{7'h5D, -1, 1'b0, 9,  0, 1'b0, 0, "early_end"};

    RESET = 1'b0; enable = 1'b1; valid_in = 1'b0; data_in = 1'b0; finished_in = 1'b0;
    #12;
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_seed_out", int'(seed_out), 0);
    chk("reset_byte_count", int'(byte_count), 0);
    chk("reset_service_err", int'(service_err), 0);
    chk("reset_done", int'(done), 0);
    #10 RESET = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // RESET pulsed in the middle of the PSDU
    build(7'h5D, -1);
    drive_bits(0, 29, 1'b0, -1);
    RESET = 1'b0;
    #1;
    chk("rst_mid_data_out", int'(data_out), 0);
    chk("rst_mid_valid_out", int'(valid_out), 0);
    chk("rst_mid_seed_out", int'(seed_out), 0);
    chk("rst_mid_byte_count", int'(byte_count), 0);
    chk("rst_mid_service_err", int'(service_err), 0);
    chk("rst_mid_done", int'(done), 0);
    #2 RESET = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // enable dropped in the middle of the PSDU
    build(7'h5D, -1);
    got.delete();
    done_cnt = 0;
    drive_bits(0, 29, 1'b0, -1);
    enable   = 1'b0;
    valid_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    valid_in = 1'b0;
    enable   = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("en_drop_done", done_cnt, 0);
    chk("en_drop_nbytes", got.size(), 1);
    chk("en_drop_byte_count", int'(byte_count), 1);
    chk("en_drop_seed_kept", int'(seed_out), 32'h5D);
    run_vec(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wifi_descrambler.md
Name: wifi_descrambler

Overview:
- Sits directly downstream of the WiFi Viterbi decode chain. Consumes the decoded serial bit stream (data/valid) and the end-of-frame flag (finished) that the chain produces.
- Recovers the 802.11 scrambler seed from the first 7 SERVICE bits and descrambles with x^7+x^4+1.
- Checks and strips the 16-bit SERVICE field, then packs the PSDU bits LSB-first into bytes for the MAC-side AHB peripheral logic.

Parameters:
- SERVICE_LEN, 16, number of leading bits that are checked and dropped (SEED_LEN bits form the seed)
- SEED_LEN, 7, scrambler length; the bits used for seed recovery
- CNT_W, 12, width of the byte counter (saturating)

Ports:
- clk  in  1  system clock
- RESET  in  1  asynchronous active-low reset
- enable  in  1  block enable; low forces IDLE and clears frame state
- valid_in  in  1  data_in qualifier (one decoded bit per high cycle)
- data_in  in  1  decoded (scrambled) bit
- finished_in  in  1  end-of-frame pulse from the decoder output buffer
- data_out  out  8  descrambled PSDU byte, first received bit in data_out[0]
- valid_out  out  1  one-cycle strobe, data_out valid
- seed_out  out  7  recovered seed; seed_out[6] = first received bit
- byte_count  out  CNT_W  PSDU bytes emitted in current/last frame
- service_err  out  1  sticky per frame: a descrambled SERVICE bit 7..15 was 1
- done  out  1  one-cycle pulse, frame closed

Behaviour:
- Clock and reset: single clock domain, reset asynchronous and active-low.
- Reset values: all outputs 0, state=IDLE, scrambler register s[7:1]=0, bit counters 0.
- FSM states are IDLE, SEED, SERVICE, DATA, DONE.
- IDLE:
  - On valid_in && enable, clear byte_count, service_err and seed_out.
  - Process that bit as seed bit 0, then go to SEED.
- SEED (bits 0..SEED_LEN-1):
  - On each valid_in: s <= {s[6:1], data_in}; the bit is not output.
  - After bit SEED_LEN-1, latch seed_out <= new s and go to SERVICE.
- Descramble rule (SERVICE and DATA):
  - fb = s[7]^s[4]
  - out = data_in^fb
  - s <= {s[6:1], fb}
- SERVICE (bits SEED_LEN..SERVICE_LEN-1):
  - If any descrambled bit is 1, set service_err (sticky until the next frame starts).
  - After bit SERVICE_LEN-1, go to DATA.
- DATA:
  - Shift descrambled bits into the byte register LSB-first, using a 3-bit position counter.
  - On the 8th bit, on the next edge: data_out=byte, valid_out=1 for one cycle, byte_count+1 (saturates at all-ones).
  - Latency: valid_out rises exactly 1 clk after the valid_in cycle that carried the byte's last bit.
- finished_in in SEED/SERVICE/DATA:
  - Go to DONE. A partial byte (tail/pad bits) is discarded and no valid_out is issued.
  - If finished_in and valid_in occur in the same cycle, the bit is processed first; this can complete a byte, in which case valid_out and done coincide on the next cycle.
- DONE: done=1 for one cycle, then IDLE. valid_in during DONE is ignored.
- finished_in in IDLE or DONE is ignored.
- valid_in gaps of any length are allowed; state holds.
- enable low in any state: synchronous return to IDLE, no done, no valid_out. seed_out, byte_count and service_err keep their values until the next frame start.
- RESET mid-frame: immediate return to reset values; the next valid_in starts a fresh frame.
- Outputs data_out, seed_out and byte_count are all registered.

Decomposition:
- Shared package wifi_phy_pkg holds:
  - FSM state encoding
  - scrambler polynomial taps (7, 4)
  - SEED_LEN and SERVICE_LEN defaults
  - byte width 8
- One natural sub-module, wifi_bit_packer: 1-bit to 8-bit LSB-first packer with strobe and a clear input. The FSM and LFSR stay in the top.

Test Plan:
- Golden frame:
  - Stimulus: software scrambler model, seed 7'b1011101, SERVICE=0, PSDU bytes 0x04,0x02,0x00,0x2E, 6 tail bits, then finished_in.
  - Required response: seed_out=7'b1011101; four valid_out strobes with those bytes; byte_count=4; service_err=0; done one cycle after finished_in.
- SERVICE corruption: same frame with received bit 10 inverted -> service_err=1, PSDU bytes unchanged, byte_count=4.
- Stall and back-to-back:
  - Stimulus: valid_in deasserted for 1..5 random cycles between bits; a second frame with seed 7'b1111111 starts 1 cycle after done.
  - Required response: identical bytes to the unstalled run; counters cleared for frame 2; its seed_out correct.
- Coincident last bit:
  - Stimulus: finished_in in the same cycle as the 8th bit of byte 3; then a separate run with finished_in arriving 5 bits into byte 4.
  - Required response: first run, valid_out and done assert together with byte_count=3. Second run, no 4th byte and byte_count=3.
- Early end: finished_in after 10 bits (in SERVICE) -> done pulse, byte_count=0, no valid_out.
- Abort:
  - Stimulus: RESET pulsed low mid-DATA; separately, enable dropped mid-DATA.
  - Required response: RESET clears all outputs to 0. enable-low returns to IDLE with no done. In both cases the following clean frame decodes correctly.
